// File: rtl/regfile_arbiter_pkg.sv
// ============================================================================
// Module  : regfile_arbiter_pkg
// Brief   : Shared widths and FSM encoding for the register-file arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package regfile_arbiter_pkg;
    localparam int RF_AW = 8;
    localparam int RF_DW = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;
endpackage

`default_nettype wire

// File: rtl/regfile_arbiter_rr_pick2.sv
// ============================================================================
// Module  : rr_pick2
// Brief   : Combinational 2-way round-robin chooser; a tie goes to the port
//           that did not own the bus last.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic any
);
    assign any    = req0 | req1;
    assign winner = (req0 & req1) ? ~last : req1;
endmodule

`default_nettype wire

// File: rtl/regfile_arbiter.sv
// ============================================================================
// Module  : regfile_arbiter
// Brief   : Burst round-robin arbiter sharing one 256x8 register file between
//           two requesters, with per-port registered read-valid.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             we0,
    input  logic [RF_AW-1:0] addr0,
    input  logic [RF_DW-1:0] wdata0,
    output logic             gnt0,
    output logic             rvalid0,
    input  logic             req1,
    input  logic             we1,
    input  logic [RF_AW-1:0] addr1,
    input  logic [RF_DW-1:0] wdata1,
    output logic             gnt1,
    output logic             rvalid1,
    output logic [RF_DW-1:0] rdata,
    output logic [RF_AW-1:0] rf_raddr,
    output logic [RF_AW-1:0] rf_waddr,
    output logic             rf_ren,
    output logic             rf_wen,
    output logic [RF_DW-1:0] rf_wdata,
    input  logic [RF_DW-1:0] rf_rdata
);
    localparam logic [3:0] c_cnt_max = 4'(BURST - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_last;
    logic       r_rvalid0;
    logic       r_rvalid1;

    logic             w_acc0;
    logic             w_acc1;
    logic             w_win;
    logic             w_any;
    logic             w_we;
    logic [RF_AW-1:0] w_addr;
    logic [RF_DW-1:0] w_wdata;

    rr_pick2 u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (r_last),
        .winner (w_win),
        .any    (w_any)
    );

    assign gnt0    = (r_state == S_OWN0);
    assign gnt1    = (r_state == S_OWN1);
    assign w_acc0  = gnt0 & req0;
    assign w_acc1  = gnt1 & req1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata   = rf_rdata;

    // Only one port can hold the grant, so the owner's fields are selected.
    always_comb begin
        w_we     = w_acc1 ? we1    : we0;
        w_addr   = w_acc1 ? addr1  : addr0;
        w_wdata  = w_acc1 ? wdata1 : wdata0;
        rf_wen   = 1'b0;
        rf_ren   = 1'b0;
        rf_waddr = '0;
        rf_raddr = '0;
        rf_wdata = '0;
        if (w_acc0 | w_acc1) begin
            if (w_we) begin
                rf_wen   = 1'b1;
                rf_waddr = w_addr;
                rf_wdata = w_wdata;
            end else begin
                rf_ren   = 1'b1;
                rf_raddr = w_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_last    <= 1'b1;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_acc0 & ~we0;
            r_rvalid1 <= w_acc1 & ~we1;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= w_win ? S_OWN1 : S_OWN0;
                        r_cnt   <= 4'd0;
                        r_last  <= w_win;
                    end
                end
                S_OWN0: begin
                    if (!req0) begin
                        r_cnt <= 4'd0;
                        if (req1) begin
                            r_state <= S_OWN1;
                            r_last  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_acc0 && r_cnt == c_cnt_max && req1) begin
                        r_state <= S_OWN1;
                        r_cnt   <= 4'd0;
                        r_last  <= 1'b1;
                    end else if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_OWN1: begin
                    if (!req1) begin
                        r_cnt <= 4'd0;
                        if (req0) begin
                            r_state <= S_OWN0;
                            r_last  <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_acc1 && r_cnt == c_cnt_max && req0) begin
                        r_state <= S_OWN0;
                        r_cnt   <= 4'd0;
                        r_last  <= 1'b0;
                    end else if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
// ============================================================================
// Module  : tb_regfile_arbiter
// Brief   : Self-checking bench: arbiter plus a behavioural 256x8 register file.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_arbiter;
    localparam int BURST = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [7:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
    logic       gnt0, gnt1, rvalid0, rvalid1, rf_ren, rf_wen;
    logic [7:0] rdata, rf_raddr, rf_waddr, rf_wdata;
    logic [7:0] rf_rdata = 8'h00;

    int checks = 0;
    int errors = 0;

    regfile_arbiter #(.BURST(BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .rf_raddr(rf_raddr), .rf_waddr(rf_waddr),
        .rf_ren(rf_ren), .rf_wen(rf_wen), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata)
    );

    always #5 clk = ~clk;

    // Register256_8 stand-in: synchronous write, one-cycle registered read.
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (rf_wen) mem[rf_waddr] <= rf_wdata;
        if (rf_ren) rf_rdata <= mem[rf_raddr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the bus, how many accesses this tenure,
    // and which read result is due next cycle.
    int         m_owner = -1;
    int         m_used = 0;
    int         m_last = 1;
    bit         m_rv0 = 0, m_rv1 = 0;
    logic [7:0] m_rd = 0;
    logic [7:0] ref_mem [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
    end

    always @(negedge clk) begin : b_model
        int         ap, nxt, o;
        bit         rq [2];
        logic       w;
        logic [7:0] a, d;
        if (!rst_n) begin
            chk("rst_gnt0", gnt0, 0);
            chk("rst_gnt1", gnt1, 0);
            chk("rst_rvalid0", rvalid0, 0);
            chk("rst_rvalid1", rvalid1, 0);
            chk("rst_ren", rf_ren, 0);
            chk("rst_wen", rf_wen, 0);
            m_owner = -1; m_used = 0; m_last = 1; m_rv0 = 0; m_rv1 = 0;
        end else begin
            rq[0] = req0; rq[1] = req1;
            ap = -1;
            if (m_owner == 0 && req0) ap = 0;
            if (m_owner == 1 && req1) ap = 1;
            w = (ap == 1) ? we1 : we0;
            a = (ap == 1) ? addr1 : addr0;
            d = (ap == 1) ? wdata1 : wdata0;

            chk("gnt0", gnt0, m_owner == 0);
            chk("gnt1", gnt1, m_owner == 1);
            chk("rf_wen", rf_wen, ap >= 0 && w);
            chk("rf_ren", rf_ren, ap >= 0 && !w);
            chk("rf_waddr", rf_waddr, (ap >= 0 && w) ? a : 8'h00);
            chk("rf_wdata", rf_wdata, (ap >= 0 && w) ? d : 8'h00);
            chk("rf_raddr", rf_raddr, (ap >= 0 && !w) ? a : 8'h00);
            chk("rvalid0", rvalid0, m_rv0);
            chk("rvalid1", rvalid1, m_rv1);
            if (m_rv0 || m_rv1) chk("rdata", rdata, m_rd);

            m_rv0 = (ap == 0) && !w;
            m_rv1 = (ap == 1) && !w;
            if (ap >= 0 && !w) m_rd = ref_mem[a];
            if (ap >= 0 && w) ref_mem[a] = d;

            if (m_owner < 0) begin
                if (rq[0] && rq[1]) nxt = 1 - m_last;
                else if (rq[0]) nxt = 0;
                else if (rq[1]) nxt = 1;
                else nxt = -1;
            end else begin
                o = m_owner;
                if (!rq[o]) begin
                    nxt = rq[1-o] ? 1 - o : -1;
                end else begin
                    m_used++;
                    nxt = (m_used >= BURST && rq[1-o]) ? 1 - o : o;
                end
            end
            if (nxt != m_owner) begin
                m_used = 0;
                if (nxt >= 0) m_last = nxt;
            end
            m_owner = nxt;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin : b_stim
        logic [16:0] g0, g1;
        logic [9:0]  h0, h1;
        logic [7:0]  rd [20];
        int          n, pulses, drops, cyc;
        bit          seen, acc, rv0_k9, rv1_k9;

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Port 1 writes 0x10=A5, then port 0 reads it back.
        @(posedge clk); #1;
        req1 = 1; we1 = 1; addr1 = 8'h10; wdata1 = 8'hA5;
        @(negedge clk); chk("t1_gnt1_first_cycle", gnt1, 0);
        @(negedge clk); chk("t1_gnt1", gnt1, 1); chk("t1_wen", rf_wen, 1);
        @(posedge clk); #1;
        req1 = 0; we1 = 0; req0 = 1; we0 = 0; addr0 = 8'h10;
        @(negedge clk); chk("t1_gnt0_first_cycle", gnt0, 0);
        @(negedge clk); chk("t1_gnt0", gnt0, 1);
        @(posedge clk); #1; req0 = 0;
        @(negedge clk); chk("t1_rvalid0", rvalid0, 1); chk("t1_rdata", rdata, 8'hA5);

        // Both requesting from reset: 4/4 alternation with no idle gap.
        do_reset();
        @(posedge clk); #1;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'h00; addr1 = 8'h80;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk); g0[k] = gnt0; g1[k] = gnt1;
            @(posedge clk); #1; addr0++; addr1++;
        end
        req0 = 0; req1 = 0;
        chk("t2_gnt0_pattern", 32'(g0), 32'h01E1E);
        chk("t2_gnt1_pattern", 32'(g1), 32'h1E1E0);

        // Port 0 alone: 20 in-order reads of 0..19, grant never drops.
        repeat (2) @(posedge clk); #1;
        req0 = 1; addr0 = 0;
        n = 0; pulses = 0; drops = 0; seen = 0; cyc = 0;
        while (pulses < 20 && cyc < 60) begin
            @(negedge clk);
            if (rvalid0) begin rd[pulses] = rdata; pulses++; end
            if (gnt0) seen = 1; else if (seen) drops++;
            acc = gnt0 && req0;
            cyc++;
            if (pulses < 20) begin
                @(posedge clk); #1;
                if (acc) begin
                    n++;
                    if (n == 20) req0 = 0; else addr0 = 8'(n);
                end
            end
        end
        chk("t3_rvalid_count", pulses, 20);
        chk("t3_gnt_drops", drops, 0);
        chk("t3_rd0", rd[0], 8'h5A);
        chk("t3_rd3", rd[3], 8'h59);
        chk("t3_rd16_written", rd[16], 8'hA5);
        chk("t3_rd19", rd[19], 8'h49);

        // Port 0 drops after 2 accesses; port 1 then gets a full burst,
        // and port 0's last-burst read completes in port 1's first cycle.
        @(posedge clk); #1; req0 = 0;
        repeat (2) @(posedge clk); #1;
        req0 = 1; addr0 = 8'd30;
        @(negedge clk); chk("t4_gnt0_first_cycle", gnt0, 0);
        @(posedge clk); #1; req1 = 1; we1 = 0; addr1 = 8'd40;
        @(negedge clk);
        @(posedge clk); #1; addr0 = 8'd31;
        @(negedge clk);
        @(posedge clk); #1; req0 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            h0[k] = gnt0; h1[k] = gnt1;
            if (k == 9) begin rv0_k9 = rvalid0; rv1_k9 = rvalid1; end
            @(posedge clk); #1;
            if (k == 0) req0 = 1;
            addr0++; addr1++;
        end
        chk("t4_gnt0_pattern", 32'(h0), 32'h1E1);
        chk("t4_gnt1_pattern", 32'(h1), 32'h21E);
        chk("t5_rvalid0_handover", rv0_k9, 1);
        chk("t5_rvalid1_handover", rv1_k9, 0);

        // Asynchronous reset mid-burst clears everything at once.
        #2 rst_n = 1'b0;
        #1;
        chk("t6_gnt0", gnt0, 0);
        chk("t6_gnt1", gnt1, 0);
        chk("t6_rvalid0", rvalid0, 0);
        chk("t6_rvalid1", rvalid1, 0);
        chk("t6_ren", rf_ren, 0);
        chk("t6_wen", rf_wen, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk); chk("t6_idle_after_release", gnt0 | gnt1, 0);
        @(negedge clk); chk("t6_gnt0_first", gnt0, 1); chk("t6_gnt1_not", gnt1, 0);
        @(posedge clk); #1; req0 = 0; req1 = 0;
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
